sdram_axil_csr: RTL

- AXI4-Lite subordinate (responder) register bank: the far end of the taxi_axil_if manager port.
- Exposes REG_CNT word-wide control/status registers to the SDRAM controller: RW control registers driven out, RO status registers sampled in.
- Emits per-register write/read strobes, so the controller can implement kick and clear-on-read behaviour.

---
 rtl/sdram_axil_csr_if.sv | 45 ++++
 rtl/sdram_axil_csr.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sdram_axil_csr_if.sv
// taxi_axil_if: AXI4-Lite channel bundle between a manager and a subordinate.
// Parameters DATA_W / ADDR_W / USER_W size the data, address and user fields.
// Modports: sub (register bank side), mgr (requesting side).
interface taxi_axil_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8,
   parameter int USER_W = 1
) ();
   logic [ADDR_W-1:0]   awaddr;
   logic [2:0]          awprot;
   logic [USER_W-1:0]   awuser;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic [USER_W-1:0]   wuser;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic [USER_W-1:0]   buser;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic [2:0]          arprot;
   logic [USER_W-1:0]   aruser;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic [USER_W-1:0]   ruser;
   logic                rvalid;
   logic                rready;

   modport sub (
      input  awaddr, awprot, awuser, awvalid, wdata, wstrb, wuser, wvalid, bready,
             araddr, arprot, aruser, arvalid, rready,
      output awready, wready, bresp, buser, bvalid, arready, rdata, rresp, ruser, rvalid
   );

   modport mgr (
      output awaddr, awprot, awuser, awvalid, wdata, wstrb, wuser, wvalid, bready,
             araddr, arprot, aruser, arvalid, rready,
      input  awready, wready, bresp, buser, bvalid, arready, rdata, rresp, ruser, rvalid
   );
endinterface

// File: rtl/sdram_axil_csr.sv
// sdram_axil_csr: AXI4-Lite subordinate register bank for the SDRAM controller.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   s_axil     AXI-Lite subordinate port (taxi_axil_if.sub)
//   ctrl_out   RW register contents, register i at [i*DATA_W +: DATA_W]
//   stat_in    read data for RO registers (RO_MASK bit set)
//   wr_pulse   one-cycle strobe per committed write (OKAY writes only)
//   rd_pulse   one-cycle strobe per read capture (non-DECERR reads only)
module sdram_axil_csr #(
   parameter int                  DATA_W  = 32,
   parameter int                  ADDR_W  = 8,
   parameter int                  REG_CNT = 8,
   parameter logic [REG_CNT-1:0]  RO_MASK = REG_CNT'(8'hC0),
   parameter logic [DATA_W-1:0]   RST_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   taxi_axil_if.sub                   s_axil,
   output logic [REG_CNT*DATA_W-1:0]  ctrl_out,
   input  logic [REG_CNT*DATA_W-1:0]  stat_in,
   output logic [REG_CNT-1:0]         wr_pulse,
   output logic [REG_CNT-1:0]         rd_pulse
);
   localparam int STRB_W = DATA_W / 8;
   localparam int LSB    = $clog2(STRB_W);
   localparam int IDX_W  = ADDR_W - LSB;

   logic [DATA_W-1:0] regs [REG_CNT];

   // control state (async reset)
   logic              rdy_en;
   logic              aw_held, w_held;
   logic              bvalid, rvalid;
   logic [1:0]        bresp, rresp;
   logic [DATA_W-1:0] rdata;

   // held write payload (no reset needed, qualified by the hold flags)
   logic [IDX_W-1:0]  aw_idx;
   logic [DATA_W-1:0] w_data;
   logic [STRB_W-1:0] w_strb;

   logic              aw_hs, w_hs, ar_hs, commit;
   logic [IDX_W-1:0]  aw_idx_new, cm_idx, ar_idx;
   logic [DATA_W-1:0] cm_data, ar_data;
   logic [STRB_W-1:0] cm_strb;
   logic [REG_CNT-1:0] cm_sel, ar_sel;
   logic              cm_ro;
   logic [1:0]        cm_resp, ar_resp;

   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                     input logic [DATA_W-1:0] new_v,
                                                     input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] res;
      res = old_v;
      for (int b = 0; b < STRB_W; b++)
         if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
      return res;
   endfunction

   // readies come purely from registered state; rdy_en keeps them low through reset
   assign s_axil.awready = rdy_en && !aw_held && !bvalid;
   assign s_axil.wready  = rdy_en && !w_held && !bvalid;
   assign s_axil.arready = rdy_en && !rvalid;
   assign s_axil.bvalid  = bvalid;
   assign s_axil.bresp   = bresp;
   assign s_axil.buser   = '0;
   assign s_axil.rvalid  = rvalid;
   assign s_axil.rresp   = rresp;
   assign s_axil.rdata   = rdata;
   assign s_axil.ruser   = '0;

   assign aw_hs      = s_axil.awvalid && s_axil.awready;
   assign w_hs       = s_axil.wvalid && s_axil.wready;
   assign ar_hs      = s_axil.arvalid && s_axil.arready;
   assign aw_idx_new = s_axil.awaddr[ADDR_W-1:LSB];
   assign ar_idx     = s_axil.araddr[ADDR_W-1:LSB];

   // commit once both halves sit in their holds, or straight away on a joint handshake
   assign commit  = (aw_held && w_held) || (aw_hs && w_hs);
   assign cm_idx  = aw_held ? aw_idx : aw_idx_new;
   assign cm_data = w_held ? w_data : s_axil.wdata;
   assign cm_strb = w_held ? w_strb : s_axil.wstrb;

   // decode via one-hot select; an all-zero select means the index is out of range
   always_comb begin
      cm_sel  = '0;
      cm_ro   = 1'b0;
      ar_sel  = '0;
      ar_data = '0;
      for (int i = 0; i < REG_CNT; i++) begin
         if (cm_idx == IDX_W'(i)) begin
            cm_sel[i] = 1'b1;
            cm_ro     = RO_MASK[i];
         end
         if (ar_idx == IDX_W'(i)) begin
            ar_sel[i] = 1'b1;
            ar_data   = RO_MASK[i] ? stat_in[i*DATA_W +: DATA_W] : regs[i];
         end
      end
      cm_resp = (cm_sel == '0) ? 2'b11 : (cm_ro ? 2'b10 : 2'b00);
      ar_resp = (ar_sel == '0) ? 2'b11 : 2'b00;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_en   <= 1'b0;
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         bvalid   <= 1'b0;
         bresp    <= 2'b00;
         rvalid   <= 1'b0;
         rresp    <= 2'b00;
         rdata    <= '0;
         wr_pulse <= '0;
         rd_pulse <= '0;
         for (int i = 0; i < REG_CNT; i++) regs[i] <= RST_VAL;
      end else begin
         rdy_en   <= 1'b1;
         wr_pulse <= '0;
         rd_pulse <= '0;
         if (aw_hs) aw_held <= 1'b1;
         if (w_hs)  w_held  <= 1'b1;
         if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= cm_resp;
            if (!cm_ro) wr_pulse <= cm_sel;
            for (int i = 0; i < REG_CNT; i++)
               if (cm_sel[i] && !RO_MASK[i])
                  regs[i] <= merge_bytes(regs[i], cm_data, cm_strb);
         end else if (bvalid && s_axil.bready) begin
            bvalid <= 1'b0;
         end
         // rdata samples the pre-commit register value on a same-edge collision
         if (ar_hs) begin
            rvalid   <= 1'b1;
            rresp    <= ar_resp;
            rdata    <= ar_data;
            rd_pulse <= ar_sel;
         end else if (rvalid && s_axil.rready) begin
            rvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (aw_hs) aw_idx <= aw_idx_new;
      if (w_hs) begin
         w_data <= s_axil.wdata;
         w_strb <= s_axil.wstrb;
      end
   end

   for (genvar g = 0; g < REG_CNT; g++) begin : g_ctrl
      assign ctrl_out[g*DATA_W +: DATA_W] = regs[g];
   end
endmodule
